link_peer: RTL

Cable-side counterpart to the Game Boy serial port: emulates the remote device at the far end of the link cable. In slave mode it follows the console's internally generated serial clock; in master mode it drives the clock for a console set to external clock. It exchanges one byte per transfer with a host-side byte interface (valid/ready TX, pulsed RX) that sits between the core's serial pins and the host bridge.

---
 rtl/link_pkg.sv | 15 +
 rtl/link_sync.sv | 33 +++
 rtl/link_peer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/link_pkg.sv
// link_pkg: shared state encoding and default configuration for the link cable peer.
package link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOW   = 2'd2,
        HIGH  = 2'd3
    } state_e;

    localparam int unsigned CLK_DIV_DEF = 511;
    localparam int unsigned TIMEOUT_DEF = 65535;
    localparam logic [7:0]  FILL_DEF    = 8'hFF;

endpackage

// File: rtl/link_sync.sv
// link_sync: 2-flop synchronizer for the console serial pins with rise/fall pulses on the clock.
module link_sync (
    input  logic clk,
    input  logic rst,
    input  logic gb_clk_i,
    input  logic gb_data_i,
    output logic rise_c_o,
    output logic fall_c_o,
    output logic data_o
);

    logic [1:0] clk_sync_q;
    logic       clk_prev_q;
    logic [1:0] data_sync_q;

    // Reset to the idle-high level so a quiet cable produces no edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            clk_prev_q  <= 1'b1;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], gb_clk_i};
            clk_prev_q  <= clk_sync_q[1];
            data_sync_q <= {data_sync_q[0], gb_data_i};
        end
    end

    assign rise_c_o = clk_sync_q[1] & ~clk_prev_q;
    assign fall_c_o = ~clk_sync_q[1] & clk_prev_q;
    assign data_o   = data_sync_q[1];

endmodule

// File: rtl/link_peer.sv
// link_peer: far-end emulation of the Game Boy link cable with a 1-deep TX holding register.
// Master mode (peer drives the serial clock) is built only when LINK_PEER_MASTER_EN is defined.
module link_peer
    import link_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter logic [7:0]  FILL    = FILL_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       start,
    input  logic       gb_clk_in,
    input  logic       gb_data_in,
    output logic       peer_clk_out,
    output logic       peer_data_out,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       err
);

    localparam int unsigned DIV_W = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
    localparam int unsigned TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e           state_q;
    logic [7:0]       hold_q;
    logic             hold_vld_q;
    logic [7:0]       shift_q;
    logic [7:0]       rx_shift_q;
    logic [2:0]       bit_cnt_q;
    logic [TMO_W-1:0] tmo_q;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             err_q;
    logic             busy_q;

    logic             clk_rise_c;
    logic             clk_fall_c;
    logic             data_s;
    logic             accept_c;
    logic             slave_go_c;
    logic [7:0]       next_byte_c;

    link_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .gb_clk_i  (gb_clk_in),
        .gb_data_i (gb_data_in),
        .rise_c_o  (clk_rise_c),
        .fall_c_o  (clk_fall_c),
        .data_o    (data_s)
    );

    // Byte that would go out next: a byte arriving this cycle wins over an empty holding register.
    assign accept_c    = tx_valid & ~hold_vld_q;
    assign next_byte_c = accept_c ? tx_data : (hold_vld_q ? hold_q : FILL);

`ifdef LINK_PEER_MASTER_EN
    logic             clk_q;
    logic [DIV_W-1:0] div_q;

    assign slave_go_c   = clk_fall_c & ~mode;
    assign peer_clk_out = clk_q;
`else
    logic unused_c;

    assign slave_go_c   = clk_fall_c;
    assign peer_clk_out = 1'b1;
    assign unused_c     = ^{mode, start, DIV_W'(0)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= 8'h00;
            hold_vld_q <= 1'b0;
            shift_q    <= FILL;
            rx_shift_q <= 8'h00;
            bit_cnt_q  <= 3'd0;
            tmo_q      <= '0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef LINK_PEER_MASTER_EN
            clk_q      <= 1'b1;
            div_q      <= '0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
            if (accept_c) begin
                hold_q     <= tx_data;
                hold_vld_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    shift_q <= next_byte_c;
`ifdef LINK_PEER_MASTER_EN
                    if (mode && start) begin
                        hold_vld_q <= 1'b0;
                        bit_cnt_q  <= 3'd0;
                        div_q      <= '0;
                        clk_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= LOW;
                    end else
`endif
                    if (slave_go_c) begin
                        hold_vld_q <= 1'b0;
                        bit_cnt_q  <= 3'd0;
                        tmo_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (clk_rise_c) begin
                        tmo_q      <= '0;
                        rx_shift_q <= {rx_shift_q[6:0], data_s};
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_q  <= {rx_shift_q[6:0], data_s};
                            rx_valid_q <= 1'b1;
                            shift_q    <= next_byte_c;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            shift_q <= {shift_q[6:0], 1'b1};
                        end
                    end else if (clk_fall_c) begin
                        tmo_q <= '0;
                    end else if (tmo_q == TMO_W'(TIMEOUT)) begin
                        // Console went silent: drop the partial byte and the committed TX byte.
                        tmo_q   <= '0;
                        err_q   <= 1'b1;
                        shift_q <= next_byte_c;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end

`ifdef LINK_PEER_MASTER_EN
                LOW: begin
                    if (div_q == DIV_W'(CLK_DIV / 2)) begin
                        div_q   <= '0;
                        clk_q   <= 1'b1;
                        state_q <= HIGH;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end

                HIGH: begin
                    // End of each high phase samples the console bit presented after the previous fall.
                    if (div_q == DIV_W'(CLK_DIV - CLK_DIV / 2 - 1)) begin
                        div_q      <= '0;
                        rx_shift_q <= {rx_shift_q[6:0], data_s};
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_q  <= {rx_shift_q[6:0], data_s};
                            rx_valid_q <= 1'b1;
                            shift_q    <= next_byte_c;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            shift_q   <= {shift_q[6:0], 1'b1};
                            clk_q     <= 1'b0;
                            state_q   <= LOW;
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
`endif

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign peer_data_out = shift_q[7];
    assign tx_ready      = ~hold_vld_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign busy          = busy_q;
    assign err           = err_q;

endmodule
